// File: rtl/lector_temperatura.sv
// Periodic 3-wire serial ADC reader with threshold/hysteresis fan and alarm flags.
// Optional 4-sample moving average of the reading when PROMEDIO_EN is defined.
module lector_temperatura #(
  parameter int         DIV           = 4,
  parameter int         PERIODO       = 1000,
  parameter logic [7:0] UMBRAL_VENT   = 8'd30,
  parameter logic [7:0] UMBRAL_ALARMA = 8'd45,
  parameter logic [7:0] HIST          = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       adc_sdata,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [7:0] temp,
  output logic       ac_ventilador,
  output logic       ac_alarma,
  output logic       lectura,
  output logic [1:0] estado_lector
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ESP_W = $clog2(PERIODO + 1);
  localparam logic [DIV_W-1:0] DIV_FIN   = DIV_W'(DIV - 1);
  localparam logic [ESP_W-1:0] ESP_CARGA = ESP_W'(PERIODO);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FIN    = 2'd2,
    ESPERA = 2'd3
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       flanco_q, flanco_d;
  logic [ESP_W-1:0] esp_q, esp_d;
  logic [15:0]      shift_q, shift_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             lect_q, lect_d;
  logic [7:0]       temp_q, temp_d;
  logic             vent_q, vent_d;
  logic             alarma_q, alarma_d;
  logic             conmuta;
  logic             fin_entrada;
  logic [7:0]       muestra;
  logic [7:0]       valor;
  logic             unused_msb;

  // A saturated clear level of 0 can never be undercut, so the flag latches.
  function automatic logic [7:0] nivel_borrado(input logic [7:0] umbral);
    logic [7:0] nivel;
    nivel = (umbral >= HIST) ? (umbral - HIST) : 8'd0;
    return nivel;
  endfunction

  function automatic logic histeresis(input logic flag, input logic [7:0] t,
                                      input logic [7:0] umbral);
    logic r;
    if (t >= umbral)                     r = 1'b1;
    else if (t < nivel_borrado(umbral))  r = 1'b0;
    else                                 r = flag;
    return r;
  endfunction

  // Bit 15 only ever holds a leading zero of the ADC frame.
  assign unused_msb = shift_q[15];

  // ---- next-state logic ----
  always_comb begin
    estado_d = estado_q;
    div_d    = div_q;
    flanco_d = flanco_q;
    esp_d    = esp_q;
    shift_d  = shift_q;
    conmuta  = 1'b0;
    case (estado_q)
      IDLE: begin
        if (en) begin
          estado_d = CONV;
          div_d    = '0;
          flanco_d = '0;
          shift_d  = '0;
        end
      end
      CONV: begin
        if (!en) begin
          estado_d = IDLE;
        end else if (div_q == DIV_FIN) begin
          div_d   = '0;
          conmuta = 1'b1;
          if (!sclk_q) begin
            shift_d  = {shift_q[14:0], adc_sdata};
            flanco_d = flanco_q + 4'd1;
            if (flanco_q == 4'd15) estado_d = FIN;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      FIN: begin
        if (!en) begin
          estado_d = IDLE;
        end else begin
          estado_d = ESPERA;
          esp_d    = ESP_CARGA;
        end
      end
      ESPERA: begin
        if (!en) begin
          estado_d = IDLE;
        end else if (esp_q <= ESP_W'(1)) begin
          esp_d    = '0;
          estado_d = CONV;
          div_d    = '0;
          flanco_d = '0;
          shift_d  = '0;
        end else begin
          esp_d = esp_q - ESP_W'(1);
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  assign fin_entrada = (estado_q == CONV) && (estado_d == FIN);
  assign muestra     = shift_d[12:5];

`ifdef PROMEDIO_EN
  logic [3:0][7:0] ventana_q, ventana_d;
  logic            primero_q;
  logic [9:0]      suma;

  function automatic logic [7:0] promedio(input logic [9:0] s);
    return s[9:2];
  endfunction

  // The first frame after reset seeds the whole window.
  always_comb begin
    if (primero_q) begin
      ventana_d = {4{muestra}};
    end else begin
      ventana_d = {ventana_q[2:0], muestra};
    end
    suma  = {2'b00, ventana_d[0]} + {2'b00, ventana_d[1]}
          + {2'b00, ventana_d[2]} + {2'b00, ventana_d[3]};
    valor = promedio(suma);
  end

  always_ff @(posedge clk) begin
    if (rst)              primero_q <= 1'b1;
    else if (fin_entrada) primero_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (fin_entrada && !rst) ventana_q <= ventana_d;
  end
`else
  assign valor = muestra;
`endif

  // ---- registered output values ----
  always_comb begin
    cs_n_d   = (estado_d != CONV);
    sclk_d   = (estado_d == CONV) ? (sclk_q ^ conmuta) : 1'b1;
    lect_d   = (estado_d == FIN);
    temp_d   = temp_q;
    vent_d   = vent_q;
    alarma_d = alarma_q;
    if (fin_entrada) begin
      temp_d   = valor;
      vent_d   = histeresis(vent_q, valor, UMBRAL_VENT);
      alarma_d = histeresis(alarma_q, valor, UMBRAL_ALARMA);
    end
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      div_q    <= '0;
      flanco_q <= '0;
      esp_q    <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      lect_q   <= 1'b0;
      temp_q   <= '0;
      vent_q   <= 1'b0;
      alarma_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      div_q    <= div_d;
      flanco_q <= flanco_d;
      esp_q    <= esp_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      lect_q   <= lect_d;
      temp_q   <= temp_d;
      vent_q   <= vent_d;
      alarma_q <= alarma_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign adc_cs_n      = cs_n_q;
  assign adc_sclk      = sclk_q;
  assign temp          = temp_q;
  assign ac_ventilador = vent_q;
  assign ac_alarma     = alarma_q;
  assign lectura       = lect_q;
  assign estado_lector = estado_q;

endmodule

// File: tb/tb_lector_temperatura.sv
// Bench for lector_temperatura: frame-timing/hysteresis reference model plus directed literal checks.
// Build with +define+PROMEDIO_EN to exercise the averaged variant.
module tb_lector_temperatura;

  localparam int DIV     = 2;
  localparam int PERIODO = 20;
  localparam int T_FIN   = 32 * DIV;
  localparam int T_CICLO = 32 * DIV + 1 + PERIODO;
`ifdef PROMEDIO_EN
  localparam int TEMP_PREVIA = 35;
`else
  localparam int TEMP_PREVIA = 42;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       adc_sdata = 1'b0;
  logic       adc_cs_n, adc_sclk, ac_ventilador, ac_alarma, lectura;
  logic [7:0] temp;
  logic [1:0] estado_lector;

  always #5 clk = ~clk;

  lector_temperatura #(.DIV(DIV), .PERIODO(PERIODO)) dut (
    .clk(clk), .rst(rst), .en(en), .adc_sdata(adc_sdata),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .temp(temp),
    .ac_ventilador(ac_ventilador), .ac_alarma(ac_alarma),
    .lectura(lectura), .estado_lector(estado_lector)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Reference model: frame phase m_t counts clk cycles since CONV entry.
  bit          m_act = 1'b0;
  int          m_t = 0;
  logic [15:0] cur_word = 16'h0000;
  logic [7:0]  m_temp = 8'd0;
  bit          m_vent = 1'b0;
  bit          m_alarma = 1'b0;
  logic [15:0] forced_q[$];
  int          win[$];

  function automatic bit hist_m(bit f, int t, int thr);
    int clr;
    clr = (thr > 2) ? thr - 2 : 0;
    if (t >= thr) return 1'b1;
    if (t < clr)  return 1'b0;
    return f;
  endfunction

  function automatic logic [15:0] palabra(input int d);
    logic [7:0] b;
    b = 8'(d);
    return {3'b000, b, 5'b10110};
  endfunction

  task automatic nueva_palabra();
    logic [7:0] d;
    if (forced_q.size() > 0) begin
      cur_word = forced_q.pop_front();
    end else begin
      if ($urandom_range(0, 3) == 0) d = 8'($urandom);
      else                           d = 8'($urandom_range(20, 50));
      cur_word = {3'($urandom), d, 5'($urandom)};
    end
  endtask

  task automatic fin_modelo();
    int s;
    int acc;
    s = int'(cur_word[12:5]);
`ifdef PROMEDIO_EN
    if (win.size() == 0) begin
      repeat (4) win.push_back(s);
    end else begin
      void'(win.pop_back());
      win.push_front(s);
    end
    acc = 0;
    foreach (win[i]) acc += win[i];
    m_temp = 8'(acc / 4);
`else
    acc = s;
    m_temp = 8'(acc);
`endif
    m_vent   = hist_m(m_vent, int'(m_temp), 30);
    m_alarma = hist_m(m_alarma, int'(m_temp), 45);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0; m_t = 0; m_temp = 8'd0; m_vent = 1'b0; m_alarma = 1'b0;
      win.delete();
    end else if (!m_act) begin
      if (en) begin m_act = 1'b1; m_t = 0; nueva_palabra(); end
    end else if (!en) begin
      m_act = 1'b0;
    end else begin
      m_t++;
      if (m_t == T_CICLO) begin m_t = 0; nueva_palabra(); end
      else if (m_t == T_FIN) fin_modelo();
    end
  end

  // ADC model: presents the next bit after each falling SCLK, MSB first.
  logic prev_sclk = 1'b1;
  int   idx = 15;
  always @(negedge clk) begin
    if (adc_cs_n !== 1'b0) idx = 15;
    else if (prev_sclk === 1'b1 && adc_sclk === 1'b0 && idx >= 0) begin
      adc_sdata = cur_word[4'(idx)];
      idx--;
    end
    prev_sclk = adc_sclk;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic       e_cs, e_sclk, e_lect;
      logic [1:0] e_est;
      logic [14:0] act, req;
      e_cs   = !(m_act && m_t < T_FIN);
      e_sclk = (m_act && m_t < T_FIN) ? ((m_t / DIV) % 2 == 0) : 1'b1;
      e_lect = m_act && (m_t == T_FIN);
      e_est  = !m_act ? 2'd0 : (m_t < T_FIN) ? 2'd1 : (m_t == T_FIN) ? 2'd2 : 2'd3;
      act = {adc_cs_n, adc_sclk, lectura, estado_lector, temp, ac_ventilador, ac_alarma};
      req = {e_cs, e_sclk, e_lect, e_est, m_temp, m_vent, m_alarma};
      n_cmp++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL ciclo @%0t: actual cs_n=%b sclk=%b lect=%b est=%0d temp=%0d vent=%b alarma=%b, required cs_n=%b sclk=%b lect=%b est=%0d temp=%0d vent=%b alarma=%b",
                 $time, adc_cs_n, adc_sclk, lectura, estado_lector, temp, ac_ventilador, ac_alarma,
                 e_cs, e_sclk, e_lect, e_est, m_temp, m_vent, m_alarma);
      end
    end
  end

  task automatic chk(input string nombre, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nombre, act, req);
    end
  endtask

  task automatic esperar_lectura(input string nombre);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (lectura !== 1'b1 && n < 400);
    if (lectura !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: lectura timeout after %0d cycles", nombre, n);
    end
  endtask

  task automatic esperar_cs_bajo(input string nombre);
    int n;
    n = 0;
    while (adc_cs_n !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    if (adc_cs_n !== 1'b0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: cs_n never went low", nombre);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, bajo;
    logic prev;
`ifndef PROMEDIO_EN
    int datos[6]  = '{30, 29, 27, 46, 44, 42};
    int e_vent[6] = '{1, 1, 0, 1, 1, 1};
    int e_alar[6] = '{0, 0, 0, 1, 1, 0};
`else
    int p_datos[4] = '{40, 40, 40, 20};
    int p_temp[4]  = '{40, 40, 40, 35};
`endif

    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;
    chk("reset_cs_n", int'(adc_cs_n), 1);
    chk("reset_sclk", int'(adc_sclk), 1);
    chk("reset_temp", int'(temp), 0);
    chk("reset_vent", int'(ac_ventilador), 0);
    chk("reset_alarma", int'(ac_alarma), 0);
    chk("reset_lectura", int'(lectura), 0);
    chk("reset_estado", int'(estado_lector), 0);
    repeat (20) @(negedge clk);
    chk("idle_cs_n", int'(adc_cs_n), 1);
    chk("idle_sclk", int'(adc_sclk), 1);

`ifndef PROMEDIO_EN
    forced_q.push_back(16'h0340);
    foreach (datos[i]) forced_q.push_back(palabra(datos[i]));
    en = 1'b1;
    esperar_cs_bajo("trama1");
    bajo = 0; r = 0; prev = adc_sclk;
    do begin
      bajo++;
      @(negedge clk);
      if (prev === 1'b0 && adc_sclk === 1'b1) r++;
      prev = adc_sclk;
    end while (adc_cs_n === 1'b0 && bajo < 1000);
    chk("cs_low_cycles", bajo, 64);
    chk("sclk_rises", r, 16);
    chk("trama1_lectura", int'(lectura), 1);
    chk("trama1_temp", int'(temp), 26);
    chk("trama1_vent", int'(ac_ventilador), 0);
    chk("trama1_alarma", int'(ac_alarma), 0);
    n = 0;
    do begin @(negedge clk); n++; end while (adc_cs_n !== 1'b0 && n < 200);
    chk("fin_a_conv", n, 21);
    foreach (datos[i]) begin
      esperar_lectura("barrido");
      chk($sformatf("barrido_temp_%0d", i), int'(temp), datos[i]);
      chk($sformatf("barrido_vent_%0d", i), int'(ac_ventilador), e_vent[i]);
      chk($sformatf("barrido_alarma_%0d", i), int'(ac_alarma), e_alar[i]);
    end
`else
    foreach (p_datos[i]) forced_q.push_back(palabra(p_datos[i]));
    en = 1'b1;
    foreach (p_datos[i]) begin
      esperar_lectura("promedio");
      chk($sformatf("promedio_temp_%0d", i), int'(temp), p_temp[i]);
      chk($sformatf("promedio_vent_%0d", i), int'(ac_ventilador), 1);
    end
`endif

    // Abort at the 8th rising SCLK edge, then a clean frame.
    forced_q.push_back(palabra(50));
    forced_q.push_back(palabra(33));
    esperar_cs_bajo("aborto");
    r = 0; n = 0; prev = adc_sclk;
    while (r < 8 && n < 300) begin
      @(negedge clk); n++;
      if (prev === 1'b0 && adc_sclk === 1'b1) r++;
      prev = adc_sclk;
    end
    chk("aborto_flancos", r, 8);
    en = 1'b0;
    @(negedge clk);
    chk("aborto_cs_n", int'(adc_cs_n), 1);
    chk("aborto_estado", int'(estado_lector), 0);
    chk("aborto_lectura", int'(lectura), 0);
    chk("aborto_temp", int'(temp), TEMP_PREVIA);
    repeat (3) @(negedge clk);
    en = 1'b1;
    esperar_lectura("reanudar");
    chk("reanudar_temp", int'(temp), 33);

    // Reset in the middle of a conversion.
    esperar_cs_bajo("rst_conv");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_conv_temp", int'(temp), 0);
    chk("rst_conv_vent", int'(ac_ventilador), 0);
    chk("rst_conv_alarma", int'(ac_alarma), 0);
    chk("rst_conv_cs_n", int'(adc_cs_n), 1);
    chk("rst_conv_estado", int'(estado_lector), 0);
    rst = 1'b0;

    // Randomized en/rst activity with random ADC words.
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (en) begin
        if ($urandom_range(0, 299) == 0) en = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        en = 1'b1;
      end
      rst = ($urandom_range(0, 2999) == 0);
    end
    rst = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
